// File: rtl/hbridge_deadtime_if.sv
// Control/gate bundle between the PWM stage and the H-bridge dead-time driver.
// fault/fault_latched exist only when HBRIDGE_FAULT_EN is defined.
interface hbridge_deadtime_if #(
  parameter int unsigned DEAD_WIDTH = 8
);
  logic                  enable;
  logic                  pwm_pulse;
  logic                  direction;
  logic                  brake;
  logic [DEAD_WIDTH-1:0] dead_time;
  logic                  high_a;
  logic                  low_a;
  logic                  high_b;
  logic                  low_b;
  logic                  busy;
`ifdef HBRIDGE_FAULT_EN
  logic                  fault;
  logic                  fault_latched;
`endif

  modport master (
    output enable, pwm_pulse, direction, brake, dead_time,
`ifdef HBRIDGE_FAULT_EN
    output fault,
    input  fault_latched,
`endif
    input  high_a, low_a, high_b, low_b, busy
  );

  modport slave (
    input  enable, pwm_pulse, direction, brake, dead_time,
`ifdef HBRIDGE_FAULT_EN
    input  fault,
    output fault_latched,
`endif
    output high_a, low_a, high_b, low_b, busy
  );
endinterface

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver: two half-bridge legs, each with a dead-time FSM.
// Define HBRIDGE_FAULT_EN to add the overcurrent fault latch.
module hbridge_deadtime #(
  parameter int unsigned DEAD_WIDTH = 8
) (
  input logic               clock,
  input logic               reset,
  hbridge_deadtime_if.slave bus
);
  localparam int unsigned NUM_LEGS = 2;

  typedef enum logic [1:0] {ST_OFF, ST_HI, ST_LO, ST_DEAD} leg_state_t;

  leg_state_t            r_state     [NUM_LEGS];
  leg_state_t            w_state_nxt [NUM_LEGS];
  leg_state_t            w_demand    [NUM_LEGS];
  logic [DEAD_WIDTH-1:0] r_cnt       [NUM_LEGS];
  logic [DEAD_WIDTH-1:0] w_cnt_nxt   [NUM_LEGS];
  logic                  w_switched  [NUM_LEGS];
  logic                  r_high      [NUM_LEGS];
  logic                  r_low       [NUM_LEGS];
  logic                  w_high_nxt  [NUM_LEGS];
  logic                  w_low_nxt   [NUM_LEGS];
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic [DEAD_WIDTH-1:0] w_dead_load;
  logic                  w_force_off;

`ifdef HBRIDGE_FAULT_EN
  logic r_fault_latched;
  logic w_fault_latched_nxt;

  // Latch sets on any fault; clears only once the bridge is disabled and fault is gone.
  always_comb begin
    w_fault_latched_nxt = r_fault_latched;
    if (bus.fault) begin
      w_fault_latched_nxt = 1'b1;
    end else if (!bus.enable) begin
      w_fault_latched_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fault_latched <= 1'b0;
    end else begin
      r_fault_latched <= w_fault_latched_nxt;
    end
  end

  assign w_force_off       = bus.fault | r_fault_latched;
  assign bus.fault_latched = r_fault_latched;
`else
  assign w_force_off = 1'b0;
`endif

  // Per-leg demand, dead-time transitions and registered gate decode.
  always_comb begin
    w_dead_load   = (bus.dead_time == '0) ? '0 : bus.dead_time - DEAD_WIDTH'(1);
    w_switched[0] = ~bus.direction;
    w_switched[1] = bus.direction;
    w_busy_nxt    = 1'b0;
    for (int i = 0; i < NUM_LEGS; i++) begin
      w_demand[i]    = ST_OFF;
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];

      if (!bus.enable) begin
        w_demand[i] = ST_OFF;
      end else if (bus.brake || !w_switched[i]) begin
        w_demand[i] = ST_LO;
      end else begin
        w_demand[i] = bus.pwm_pulse ? ST_HI : ST_LO;
      end

      case (r_state[i])
        ST_OFF: begin
          w_state_nxt[i] = w_demand[i];
        end
        ST_HI, ST_LO: begin
          if (w_demand[i] != r_state[i]) begin
            w_state_nxt[i] = ST_DEAD;
            w_cnt_nxt[i]   = w_dead_load;
          end
        end
        ST_DEAD: begin
          if (r_cnt[i] != '0) begin
            w_cnt_nxt[i] = r_cnt[i] - DEAD_WIDTH'(1);
          end else begin
            w_state_nxt[i] = w_demand[i];
          end
        end
        default: begin
          w_state_nxt[i] = ST_OFF;
        end
      endcase

      // A fault drops the gates on the same edge, skipping any dead interval.
      if (w_force_off) begin
        w_state_nxt[i] = ST_OFF;
        w_cnt_nxt[i]   = '0;
      end

      w_high_nxt[i] = (w_state_nxt[i] == ST_HI);
      w_low_nxt[i]  = (w_state_nxt[i] == ST_LO);
      w_busy_nxt    = w_busy_nxt | (w_state_nxt[i] == ST_DEAD);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEGS; i++) begin
        r_state[i] <= ST_OFF;
        r_cnt[i]   <= '0;
        r_high[i]  <= 1'b0;
        r_low[i]   <= 1'b0;
      end
      r_busy <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEGS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_high[i]  <= w_high_nxt[i];
        r_low[i]   <= w_low_nxt[i];
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.high_a = r_high[0];
  assign bus.low_a  = r_low[0];
  assign bus.high_b = r_high[1];
  assign bus.low_b  = r_low[1];
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_hbridge_deadtime.sv
// Scoreboard bench for hbridge_deadtime: timestamp-based dead-time model,
// directed scenarios followed by randomized stimulus.
module tb_hbridge_deadtime;
  localparam int unsigned DW = 8;

  logic clock = 1'b0;
  logic reset;

  hbridge_deadtime_if #(.DEAD_WIDTH(DW)) bus ();

  hbridge_deadtime #(.DEAD_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic ha;
    logic la;
    logic hb;
    logic lb;
    logic busy;
    logic fl;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: each leg is either showing a steady gate (cur: 0 off, 1 high, 2 low)
  // or waiting for the cycle number at which its dead interval ends.
  int     m_cur      [2];
  longint m_dead_end [2];
  longint m_cyc;
  bit     m_fl;

  // Current stimulus values
  bit       s_rst, s_en, s_pwm, s_dir, s_brk, s_flt;
  bit [7:0] s_dt;

  function automatic int demand(int leg, bit en, bit brk, bit dir, bit pwm);
    if (!en) return 0;
    if (brk) return 2;
    if ((leg == 1) == dir) return pwm ? 1 : 2;
    return 2;
  endfunction

  function automatic void model_edge();
    int     d;
    longint dur;
    m_cyc++;
    dur = (s_dt == 8'd0) ? 1 : longint'(s_dt);
    if (!s_rst) begin
      m_fl = 1'b0;
      for (int l = 0; l < 2; l++) begin m_cur[l] = 0; m_dead_end[l] = -1; end
    end else if (s_flt || m_fl) begin
      if (s_flt) m_fl = 1'b1;
      else if (!s_en) m_fl = 1'b0;
      for (int l = 0; l < 2; l++) begin m_cur[l] = 0; m_dead_end[l] = -1; end
    end else begin
      for (int l = 0; l < 2; l++) begin
        d = demand(l, s_en, s_brk, s_dir, s_pwm);
        if (m_dead_end[l] >= 0) begin
          if (m_cyc >= m_dead_end[l]) begin
            m_cur[l]      = d;
            m_dead_end[l] = -1;
          end
        end else if (m_cur[l] == 0) begin
          m_cur[l] = d;
        end else if (d != m_cur[l]) begin
          m_cur[l]      = 0;
          m_dead_end[l] = m_cyc + dur;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.ha   = (m_dead_end[0] < 0) && (m_cur[0] == 1);
    e.la   = (m_dead_end[0] < 0) && (m_cur[0] == 2);
    e.hb   = (m_dead_end[1] < 0) && (m_cur[1] == 1);
    e.lb   = (m_dead_end[1] < 0) && (m_cur[1] == 2);
    e.busy = (m_dead_end[0] >= 0) || (m_dead_end[1] >= 0);
    e.fl   = m_fl;
    return e;
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      reset         = s_rst;
      bus.enable    = s_en;
      bus.pwm_pulse = s_pwm;
      bus.direction = s_dir;
      bus.brake     = s_brk;
      bus.dead_time = s_dt;
`ifdef HBRIDGE_FAULT_EN
      bus.fault     = s_flt;
`endif
      @(posedge clock);
      model_edge();
      sb_q.push_back(model_out());
    end
  endtask

  // Monitor: one scoreboard entry per clock, compared mid-cycle.
  always @(negedge clock) begin
    exp_t act;
    exp_t e;
    act.ha   = bus.high_a;
    act.la   = bus.low_a;
    act.hb   = bus.high_b;
    act.lb   = bus.low_b;
    act.busy = bus.busy;
`ifdef HBRIDGE_FAULT_EN
    act.fl   = bus.fault_latched;
`else
    act.fl   = 1'b0;
`endif
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL gates t=%0t actual{ha,la,hb,lb,busy,fl}=%b required=%b", $time, act, e);
      end
      if ((act.ha & act.la) | (act.hb & act.lb)) begin
        n_err++;
        $display("FAIL shoot_through t=%0t actual=%b required=no leg with both gates on", $time, act);
      end
    end
  end

  initial begin
    m_cyc = 0;
    m_fl  = 1'b0;
    for (int l = 0; l < 2; l++) begin m_cur[l] = 0; m_dead_end[l] = -1; end
    reset = 1'b0; bus.enable = 1'b1; bus.pwm_pulse = 1'b1; bus.direction = 1'b0;
    bus.brake = 1'b0; bus.dead_time = 8'd4;
`ifdef HBRIDGE_FAULT_EN
    bus.fault = 1'b0;
`endif
    s_rst = 0; s_en = 1; s_pwm = 1; s_dir = 0; s_brk = 0; s_dt = 8'd4; s_flt = 0;

    // Reset with active demand, then release (from OFF, no dead time)
    step(3);
    s_rst = 1; step(6);
    // PWM toggles with dead_time 4
    s_pwm = 0; step(8);
    s_pwm = 1; step(8);
    // Minimum dead time
    s_dt = 8'd0; s_pwm = 0; step(4);
    s_pwm = 1; step(4);
    // Direction flip, dead_time 3
    s_dt = 8'd3; step(4);
    s_dir = 1; step(6);
    s_dir = 0; step(6);
    // Short low glitch absorbed inside dead_time 5
    s_dt = 8'd5; s_pwm = 0; step(2);
    s_pwm = 1; step(8);
    // dead_time change during DEAD must not alter the interval
    s_pwm = 0; step(1);
    s_dt = 8'd1; step(6);
    // Brake during DEAD
    s_dt = 8'd5; s_pwm = 1; step(2);
    s_brk = 1; step(8);
    s_brk = 0; step(8);
    // Coast through dead time, then re-enable from OFF
    s_en = 0; step(8);
    s_en = 1; step(4);
    // Reset in the middle of DEAD
    s_pwm = 0; step(2);
    s_rst = 0; step(1);
    s_rst = 1; step(4);
`ifdef HBRIDGE_FAULT_EN
    s_pwm = 1; step(8);
    s_flt = 1; step(1);
    s_flt = 0; step(4);
    s_en = 0; step(1);
    s_en = 1; step(4);
`endif

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) s_pwm = ~s_pwm;
      if ($urandom_range(19, 0) == 0) s_dir = ~s_dir;
      if ($urandom_range(29, 0) == 0) s_brk = ~s_brk;
      if ($urandom_range(39, 0) == 0) s_en = ~s_en;
      if ($urandom_range(24, 0) == 0) s_dt = 8'($urandom_range(7, 0));
      s_rst = ($urandom_range(199, 0) != 0);
`ifdef HBRIDGE_FAULT_EN
      s_flt = ($urandom_range(149, 0) == 0);
`endif
      step(1);
    end

    repeat (3) @(negedge clock);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d entries left required=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
